// File: rtl/hlsm_seq_pkg.sv
// hlsm_seq_pkg: shared state enum, response entry type and default sizes for the HLSM run sequencer.
package hlsm_seq_pkg;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_LATENCY = 10;
  localparam int DEF_TIMEOUT = 40;
  localparam int DEF_DEPTH   = 4;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;
  typedef struct packed {
    logic signed [DEF_WIDTH-1:0] z;
    logic signed [DEF_WIDTH-1:0] x;
    logic                        timeout;
`ifdef HLSM_SEQ_LATCHK_EN
    logic [7:0]                  cycles;
`endif
  } rsp_entry_t;
endpackage

// File: rtl/hlsm_rsp_fifo.sv
// hlsm_rsp_fifo: first-word-fall-through FIFO of W-bit entries with full/empty flags.
module hlsm_rsp_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp, rp;
  logic         do_pop, do_push;
  assign empty   = wp == rp;
  assign full    = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign dout    = mem[rp[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/hlsm_run_sequencer.sv
// hlsm_run_sequencer: launches one HLSM run at a time, waits for Done with timeout, queues results.
// Define HLSM_SEQ_LATCHK_EN to record the measured Start-to-Done count per entry (rsp_cycles/rsp_late).
module hlsm_run_sequencer
  import hlsm_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic signed [WIDTH-1:0] req_a,
  input  logic signed [WIDTH-1:0] req_b,
  input  logic signed [WIDTH-1:0] req_c,
  input  logic signed [WIDTH-1:0] req_one,
  output logic                    Start,
  output logic signed [WIDTH-1:0] a,
  output logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] c,
  output logic signed [WIDTH-1:0] one,
  input  logic                    Done,
  input  logic signed [WIDTH-1:0] z_in,
  input  logic signed [WIDTH-1:0] x_in,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic signed [WIDTH-1:0] rsp_z,
  output logic signed [WIDTH-1:0] rsp_x,
  output logic                    rsp_timeout,
  output logic                    busy
`ifdef HLSM_SEQ_LATCHK_EN
  ,
  output logic [7:0]              rsp_cycles,
  output logic                    rsp_late
`endif
);
  localparam int CW = $clog2((TIMEOUT > LATENCY ? TIMEOUT : LATENCY) + 1);
  typedef struct packed {
    logic signed [WIDTH-1:0] z;
    logic signed [WIDTH-1:0] x;
    logic                    timeout;
`ifdef HLSM_SEQ_LATCHK_EN
    logic [7:0]              cycles;
`endif
  } entry_t;
  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          accept, timed_out, push, full, empty;
  entry_t        push_d, head;
  assign req_ready = state == IDLE && !full;
  assign accept    = req_valid && req_ready;
  assign timed_out = cnt == CW'(TIMEOUT);
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
      a     <= '0;
      b     <= '0;
      c     <= '0;
      one   <= '0;
    end else begin
      state <= state_n;
      cnt   <= state == LAUNCH ? CW'(1) : (state == WAIT && !timed_out) ? cnt + 1'b1 : cnt;
      if (accept) begin
        a   <= req_a;
        b   <= req_b;
        c   <= req_c;
        one <= req_one;
      end
    end
  end
  // Done takes priority over the timeout when both land in the same WAIT cycle.
  always_comb begin
    state_n        = state == IDLE   ? (accept ? LAUNCH : IDLE) :
                     state == LAUNCH ? WAIT :
                     (Done || timed_out) ? IDLE : WAIT;
    push           = state == WAIT && (Done || timed_out);
    push_d         = '0;
    push_d.z       = Done ? z_in : '0;
    push_d.x       = Done ? x_in : '0;
    push_d.timeout = !Done;
`ifdef HLSM_SEQ_LATCHK_EN
    push_d.cycles  = 8'(cnt);
`endif
  end
  assign Start = state == LAUNCH;
  assign busy  = state != IDLE;
  hlsm_rsp_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk  (Clk),
    .rst  (Rst),
    .push (push),
    .din  (push_d),
    .pop  (rsp_ready),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  assign rsp_valid   = !empty;
  assign rsp_z       = head.z;
  assign rsp_x       = head.x;
  assign rsp_timeout = head.timeout;
`ifdef HLSM_SEQ_LATCHK_EN
  assign rsp_cycles  = head.cycles;
  assign rsp_late    = head.cycles != 8'(LATENCY);
`endif
endmodule

// File: tb/tb_hlsm_run_sequencer.sv
// tb_hlsm_run_sequencer: randomized runs against a stub HLSM, checked against a queue-based response model.
module tb_hlsm_run_sequencer;
  localparam int W = 32, LAT = 10, TO = 40, DEPTH = 4;
  logic Clk = 0, Rst = 1;
  logic req_valid = 0, rsp_ready = 0, stray = 0;
  logic [W-1:0] req_a = 0, req_b = 0, req_c = 0, req_one = 0;
  logic req_ready, Start, Done, rsp_valid, rsp_timeout, busy;
  logic [W-1:0] a, b, c, one, z_in, x_in, rsp_z, rsp_x;
`ifdef HLSM_SEQ_LATCHK_EN
  logic [7:0] rsp_cycles;
  logic       rsp_late;
`endif
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic [W-1:0] z;
    logic [W-1:0] x;
    logic         to;
    int           cyc;
  } exp_t;
  exp_t exp_q[$];
  always #5 Clk = ~Clk;
  hlsm_run_sequencer #(.WIDTH(W), .LATENCY(LAT), .TIMEOUT(TO), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_one(req_one),
    .Start(Start), .a(a), .b(b), .c(c), .one(one),
    .Done(Done), .z_in(z_in), .x_in(x_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_z(rsp_z), .rsp_x(rsp_x),
    .rsp_timeout(rsp_timeout), .busy(busy)
`ifdef HLSM_SEQ_LATCHK_EN
    , .rsp_cycles(rsp_cycles), .rsp_late(rsp_late)
`endif
  );
  // Stub HLSM: asserts Done when its count since Start reaches dly (never when dly < 1).
  logic armed = 0;
  int sc = 0, dly = -1;
  logic [W-1:0] stub_z = 0, stub_x = 0;
  always @(posedge Clk) begin
    if (Start) begin
      armed <= 1;
      sc    <= 1;
    end else begin
      sc <= sc + 1;
      if (Done) armed <= 0;
    end
  end
  assign Done = stray || (armed && sc == dly);
  assign z_in = stub_z;
  assign x_in = stub_x;
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic head_check();
    check("rsp_valid_head", rsp_valid, 1);
    check("rsp_z", rsp_z, exp_q[0].z);
    check("rsp_x", rsp_x, exp_q[0].x);
    check("rsp_timeout", rsp_timeout, exp_q[0].to);
`ifdef HLSM_SEQ_LATCHK_EN
    check("rsp_cycles", rsp_cycles, 8'(exp_q[0].cyc));
    check("rsp_late", rsp_late, exp_q[0].cyc != LAT);
`endif
  endtask
  task automatic pop_head();
    if (exp_q.size() == 0) begin
      check("pop_model_empty", rsp_valid, 0);
      return;
    end
    head_check();
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    void'(exp_q.pop_front());
    check("rsp_valid_after_pop", rsp_valid, exp_q.size() != 0);
  endtask
  task automatic run(input int d, input logic [W-1:0] ra, rb, rc, ro, zz, xx, input bit pop_cap);
    int w, n;
    bit ok, popped;
    w = 0;
    while (!req_ready && w < 100) begin
      tick();
      w++;
    end
    check("req_ready_idle", req_ready, 1);
    req_valid = 1;
    req_a = ra; req_b = rb; req_c = rc; req_one = ro;
    dly = d; stub_z = zz; stub_x = xx;
    tick();
    req_valid = 0;
    req_a = $urandom; req_b = $urandom; req_c = $urandom; req_one = $urandom;
    check("launch_ctl", {Start, busy, req_ready}, 3'b110);
    check("ops_launch", {a, b, c, one}, {ra, rb, rc, ro});
    ok = d >= 1 && d <= TO;
    n = ok ? d : TO;
    popped = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      check("wait_ctl", {Start, busy, req_ready}, 3'b010);
      check("ops_hold", {a, b, c, one}, {ra, rb, rc, ro});
      if (k == n && pop_cap && exp_q.size() > 0) begin
        head_check();
        rsp_ready = 1;
        popped = 1;
      end
    end
    tick();
    rsp_ready = 0;
    if (popped) void'(exp_q.pop_front());
    exp_q.push_back('{ok ? zz : '0, ok ? xx : '0, !ok, n});
    check("done_idle", {busy, rsp_valid, req_ready}, {1'b0, 1'b1, exp_q.size() < DEPTH});
  endtask
  initial begin
    repeat (2) tick();
    check("rst_ctl", {Start, busy, rsp_valid}, 3'b000);
    check("rst_ops", {a, b, c, one}, 128'd0);
    Rst = 0;
    tick();
    check("idle_ready", {req_ready, busy}, 2'b10);
    run(LAT, 5, 3, 1, 1, 'h11, 'h22, 0);
    pop_head();
    run(-1, 7, 8, 9, 1, 'h33, 'h44, 0);
    pop_head();
    run(TO, 1, 2, 3, 4, 'h55, 'h66, 0);
    pop_head();
    run(12, 2, 4, 6, 1, 'h77, 'h88, 0);
    pop_head();
    for (int i = 0; i < DEPTH; i++)
      run($urandom_range(1, TO), $urandom, $urandom, $urandom, 1, $urandom, $urandom, 0);
    check("full_not_ready", req_ready, 0);
    req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("full_no_accept", {Start, busy}, 2'b00);
    end
    req_valid = 0;
    pop_head();
    check("ready_after_pop", req_ready, 1);
    while (exp_q.size() > 0) pop_head();
    stray = 1;
    tick();
    stray = 0;
    check("stray_done", {busy, rsp_valid, Start}, 3'b000);
    tick();
    check("stray_done_after", {busy, rsp_valid, req_ready}, 3'b001);
    req_valid = 1;
    req_a = 9; req_b = 9; req_c = 9; req_one = 9;
    dly = LAT; stub_z = 'hAA; stub_x = 'hBB;
    tick();
    req_valid = 0;
    repeat (5) tick();
    Rst = 1;
    tick();
    Rst = 0;
    check("midrun_rst_ctl", {Start, busy, rsp_valid, req_ready}, 4'b0001);
    check("midrun_rst_ops", {a, b, c, one}, 128'd0);
    repeat (4) tick();
    check("stale_done_present", Done, 1);
    tick();
    check("stale_done_ignored", {busy, rsp_valid}, 2'b00);
    run(LAT, 11, 12, 13, 14, 'h99, 'h98, 0);
    pop_head();
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == DEPTH) pop_head();
      run($urandom_range(0, 9) == 0 ? -1 : $urandom_range(1, TO + 5),
          $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) pop_head();
    end
    while (exp_q.size() > 0) pop_head();
    check("final_empty", {rsp_valid, busy}, 2'b00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
